device_tlb_frontend: RTL and testbench
======================================

// Module: device_tlb_frontend
// PURPOSE
// - Blocking, fully associative translation cache in front of device_pt_walker; device clients send VPNs here.
// - A hit is answered from the cache. A miss sends one walk request to the walker, waits for its result, fills a slot and responds.
// - Sits between client AXI logic (upstream) and device_pt_walker (downstream); one miss outstanding at a time.
// PARAMETERS
// - VPN_W    20  virtual page number width
// - PPN_W    20  physical page number width
// - ENTRIES  8   number of cache slots; power of two, 2..32
// - ID_W     4   request tag width; echoed on the response
// PORTS
// - ACLK         in   1      clock; all logic on the rising edge
// - ARESET       in   1      asynchronous, active-high reset
// - req_valid    in   1      translation request valid
// - req_ready    out  1      request accepted when valid&ready
// - req_vpn      in   VPN_W  VPN to translate
// - req_id       in   ID_W   request tag
// - rsp_valid    out  1      response valid
// - rsp_ready    in   1      response consumed when valid&ready
// - rsp_ppn      out  PPN_W  translated PPN; 0 when rsp_fault=1
// - rsp_id       out  ID_W   tag of the request being answered
// - rsp_fault    out  1      walker reported a fault
// - walk_valid   out  1      walk request to device_pt_walker
// - walk_ready   in   1      walker accepts the walk
// - walk_vpn     out  VPN_W  VPN to walk
// - walk_done    in   1      one-cycle pulse: walk result valid
// - walk_ppn     in   PPN_W  walk result PPN
// - walk_fault   in   1      walk result fault
// - flush        in   1      one-cycle pulse: invalidate all slots
// BEHAVIOUR
// - Reset: all outputs 0, all valid bits 0, victim pointer 0, state IDLE, flush_pend 0.
// - States:
//   - IDLE: req_ready=1 (0 if flush=1 that cycle). On accept, latch vpn and id, go LOOKUP.
//   - LOOKUP: compare the latched vpn against every valid slot.
//     - Hit: latch ppn, go RESP.
//     - Miss: go WREQ.
//   - WREQ: walk_valid=1 and walk_vpn held stable until walk_ready, then go WWAIT. walk_done is ignored here.
//   - WWAIT: on walk_done, latch walk_ppn and walk_fault, go RESP.
//     - Fill slot[victim] only when walk_fault=0 and flush_pend=0; then victim=(victim+1)%ENTRIES.
//     - Faults are never cached.
//   - RESP: rsp_valid=1; ppn/id/fault held stable until rsp_ready, then go IDLE. req_ready stays 0 until IDLE.
// - Latency:
//   - Hit: accept at cycle N, rsp_valid at N+2.
//   - Miss: walk_valid at N+2; rsp_valid 1 cycle after walk_done.
// - Flush:
//   - Clears all valid bits next edge, in any state. The victim pointer is not reset.
//   - Flush in WREQ or WWAIT sets flush_pend; the following fill is suppressed. The response is still returned. flush_pend clears on leaving WWAIT.
//   - Flush in the same cycle as walk_done: flush wins; no slot written.
// - Blocking operation means duplicate VPNs never coexist; multi-hit is impossible.
// - Reset mid-walk: return to IDLE. A late walk_done in IDLE is ignored.
// CONFIGURATION
// - DEVICE_TLB_STATS_EN defined: adds the following ports:
//   - hit_cnt  out 32  count of LOOKUP hits
//   - miss_cnt out 32  count of LOOKUP misses
//   - stats_clr in 1   synchronous clear
//   - Counters saturate at 32'hFFFF_FFFF. stats_clr has priority over an increment in the same cycle. Reset value 0.
// - Not defined: those ports and counters are absent; all other behaviour is identical.
// TESTING
// - Cold miss, vpn=0x00012: walk_vpn=0x00012; walker returns ppn=0x0ABCD -> rsp_ppn=0x0ABCD, fault=0, id echoed.
// - Repeat vpn=0x00012 -> no walk_valid; rsp_valid exactly 2 cycles after accept; ppn=0x0ABCD.
// - Fill vpn 0x1..0x9 (ENTRIES=8), then request 0x1 -> miss (evicted); request 0x9 -> hit.
// - Walk returns fault=1 for vpn=0x00077 -> rsp_fault=1, rsp_ppn=0; repeat request -> walks again.
// - Flush pulse during WWAIT for vpn=0x00033 -> response delivered; next request for 0x00033 misses.
// - Hold rsp_ready=0 for 5 cycles -> rsp fields stable and req_ready=0. With STATS_EN: hit_cnt/miss_cnt match the sequence.

Source files
------------

// File: rtl/device_tlb_frontend.sv
// Blocking fully associative device TLB: hit answers 2 cycles after accept, miss 1 cycle after walk_done.
// req_ready stays low until the response is taken; DEVICE_TLB_STATS_EN adds hit/miss counters.
module device_tlb_frontend #(
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 20,
  parameter int ENTRIES = 8,
  parameter int ID_W    = 4
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [VPN_W-1:0] req_vpn,
  input  logic [ID_W-1:0]  req_id,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [PPN_W-1:0] rsp_ppn,
  output logic [ID_W-1:0]  rsp_id,
  output logic             rsp_fault,
  output logic             walk_valid,
  input  logic             walk_ready,
  output logic [VPN_W-1:0] walk_vpn,
  input  logic             walk_done,
  input  logic [PPN_W-1:0] walk_ppn,
  input  logic             walk_fault,
  input  logic             flush
`ifdef DEVICE_TLB_STATS_EN
  ,
  output logic [31:0]      hit_cnt,
  output logic [31:0]      miss_cnt,
  input  logic             stats_clr
`endif
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WREQ,
    S_WWAIT,
    S_RESP
  } state_t;

  state_t             state;
  logic               ready_q;
  logic [VPN_W-1:0]   cur_vpn;
  logic [VPN_W-1:0]   tag_vpn [ENTRIES];
  logic [PPN_W-1:0]   tag_ppn [ENTRIES];
  logic [ENTRIES-1:0] slot_vld;
  logic [IDX_W-1:0]   victim;
  logic               flush_pend;
  logic               hit;
  logic [PPN_W-1:0]   hit_ppn;
  logic               accept;
  logic               fill;

  assign req_ready = ready_q & ~flush;
  assign accept    = req_valid & req_ready;
  // A flush racing the walk result, or any flush seen during the walk, drops the fill.
  assign fill      = (state == S_WWAIT) & walk_done & ~walk_fault & ~flush_pend & ~flush;

  // Duplicate VPNs cannot coexist, so an OR-merge of matching slots is exact.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (slot_vld[i] && (tag_vpn[i] == cur_vpn)) begin
        hit     = 1'b1;
        hit_ppn = hit_ppn | tag_ppn[i];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (fill) begin
      tag_vpn[victim] <= cur_vpn;
      tag_ppn[victim] <= walk_ppn;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= S_IDLE;
      ready_q    <= 1'b0;
      cur_vpn    <= '0;
      slot_vld   <= '0;
      victim     <= '0;
      flush_pend <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_ppn    <= '0;
      rsp_id     <= '0;
      rsp_fault  <= 1'b0;
      walk_valid <= 1'b0;
      walk_vpn   <= '0;
    end else begin
      if (flush) begin
        slot_vld <= '0;
      end else if (fill) begin
        slot_vld[victim] <= 1'b1;
      end
      if (fill) begin
        victim <= victim + IDX_W'(1);
      end

      case (state)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q <= 1'b0;
            cur_vpn <= req_vpn;
            rsp_id  <= req_id;
            state   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            rsp_ppn   <= hit_ppn;
            rsp_fault <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            walk_valid <= 1'b1;
            walk_vpn   <= cur_vpn;
            state      <= S_WREQ;
          end
        end
        S_WREQ: begin
          if (flush) begin
            flush_pend <= 1'b1;
          end
          if (walk_ready) begin
            walk_valid <= 1'b0;
            state      <= S_WWAIT;
          end
        end
        S_WWAIT: begin
          if (walk_done) begin
            rsp_ppn    <= walk_fault ? '0 : walk_ppn;
            rsp_fault  <= walk_fault;
            rsp_valid  <= 1'b1;
            flush_pend <= 1'b0;
            state      <= S_RESP;
          end else if (flush) begin
            flush_pend <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ready_q   <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DEVICE_TLB_STATS_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (stats_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit && (hit_cnt != 32'hFFFF_FFFF)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (!hit && (miss_cnt != 32'hFFFF_FFFF)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_device_tlb_frontend.sv
// Bench for device_tlb_frontend: directed scenarios plus randomized traffic against a fill-history cache model.
module tb_device_tlb_frontend;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        req_valid;
  logic        req_ready;
  logic [19:0] req_vpn;
  logic [3:0]  req_id;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [19:0] rsp_ppn;
  logic [3:0]  rsp_id;
  logic        rsp_fault;
  logic        walk_valid;
  logic        walk_ready;
  logic [19:0] walk_vpn;
  logic        walk_done;
  logic [19:0] walk_ppn;
  logic        walk_fault;
  logic        flush;
`ifdef DEVICE_TLB_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic        stats_clr;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Model: the valid translations are the most recent 8 successful fills since the last flush.
  typedef struct {
    logic [19:0] vpn;
    logic [19:0] ppn;
  } ent_t;
  ent_t cache[$];

  always #5 ACLK = ~ACLK;

  device_tlb_frontend #(.VPN_W(20), .PPN_W(20), .ENTRIES(8), .ID_W(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn), .req_id(req_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ppn(rsp_ppn), .rsp_id(rsp_id),
    .rsp_fault(rsp_fault),
    .walk_valid(walk_valid), .walk_ready(walk_ready), .walk_vpn(walk_vpn),
    .walk_done(walk_done), .walk_ppn(walk_ppn), .walk_fault(walk_fault),
    .flush(flush)
`ifdef DEVICE_TLB_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .stats_clr(stats_clr)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_fill(input logic [19:0] vpn, input logic [19:0] ppn);
    ent_t e;
    e.vpn = vpn;
    e.ppn = ppn;
    cache.push_back(e);
    if (cache.size() > 8) void'(cache.pop_front());
  endtask

  // One complete request; flush_mode 0 none, 1 flush inside the walk wait, 2 flush with walk_done.
  task automatic transact(input logic [19:0] vpn, input logic [3:0] id, input logic [19:0] wppn,
                          input logic wfault, input int flush_mode, input int hold);
    logic        exp_hit;
    logic [19:0] exp_ppn;
    logic        exp_fault;
    bit          got;
    int          nw;
    exp_hit = 1'b0;
    exp_ppn = '0;
    exp_fault = 1'b0;
    foreach (cache[i]) begin
      if (cache[i].vpn == vpn) begin
        exp_hit = 1'b1;
        exp_ppn = cache[i].ppn;
      end
    end
    req_vpn = vpn;
    req_id = id;
    req_valid = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (req_ready === 1'b1) got = 1;
      @(posedge ACLK);
      if (got) break;
      @(negedge ACLK);
    end
    #1 req_valid = 1'b0;
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL accept_timeout vpn=%h: req_ready never 1", vpn);
      @(negedge ACLK);
      return;
    end
    @(negedge ACLK);
    n_cmp++;
    if (rsp_valid !== 1'b0 || walk_valid !== 1'b0 || req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL lookup_cycle vpn=%h: rsp_valid=%b walk_valid=%b req_ready=%b, want 0 0 0",
               vpn, rsp_valid, walk_valid, req_ready);
    end
    @(negedge ACLK);
    if (exp_hit) begin
      exp_hits++;
      n_cmp++;
      if (rsp_valid !== 1'b1 || walk_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hit_latency vpn=%h: rsp_valid=%b walk_valid=%b, want 1 0", vpn, rsp_valid, walk_valid);
      end
    end else begin
      exp_misses++;
      n_cmp++;
      if (walk_valid !== 1'b1 || walk_vpn !== vpn) begin
        n_err++;
        $display("FAIL walk_req: walk_valid=%b walk_vpn=%h, want 1 %h", walk_valid, walk_vpn, vpn);
      end
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) begin
        walk_done = 1'($urandom_range(0, 1));
        walk_ppn = 20'($urandom);
        @(negedge ACLK);
        walk_done = 1'b0;
        n_cmp++;
        if (walk_valid !== 1'b1 || walk_vpn !== vpn || rsp_valid !== 1'b0) begin
          n_err++;
          $display("FAIL walk_hold: walk_valid=%b walk_vpn=%h rsp_valid=%b, want 1 %h 0",
                   walk_valid, walk_vpn, rsp_valid, vpn);
        end
      end
      walk_ready = 1'b1;
      @(posedge ACLK);
      #1 walk_ready = 1'b0;
      nw = $urandom_range(0, 3);
      if (flush_mode == 1 && nw == 0) nw = 1;
      for (int k = 0; k < nw; k++) begin
        @(negedge ACLK);
        flush = (flush_mode == 1 && k == 0);
        n_cmp++;
        if (rsp_valid !== 1'b0 || walk_valid !== 1'b0) begin
          n_err++;
          $display("FAIL walk_wait: rsp_valid=%b walk_valid=%b, want 0 0", rsp_valid, walk_valid);
        end
      end
      @(negedge ACLK);
      flush = (flush_mode == 2);
      walk_done = 1'b1;
      walk_ppn = wppn;
      walk_fault = wfault;
      @(posedge ACLK);
      #1;
      walk_done = 1'b0;
      walk_fault = 1'b0;
      flush = 1'b0;
      walk_ppn = 20'($urandom);
      if (flush_mode != 0) cache.delete();
      else if (!wfault) model_fill(vpn, wppn);
      exp_ppn = wfault ? 20'h0 : wppn;
      exp_fault = wfault;
      @(negedge ACLK);
      n_cmp++;
      if (rsp_valid !== 1'b1) begin
        n_err++;
        $display("FAIL miss_rsp_latency vpn=%h: rsp_valid=%b, want 1", vpn, rsp_valid);
      end
    end
    n_cmp++;
    if (rsp_ppn !== exp_ppn || rsp_id !== id || rsp_fault !== exp_fault) begin
      n_err++;
      $display("FAIL rsp_fields vpn=%h: ppn=%h id=%h fault=%b, want %h %h %b",
               vpn, rsp_ppn, rsp_id, rsp_fault, exp_ppn, id, exp_fault);
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge ACLK);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_ppn !== exp_ppn || rsp_id !== id ||
          rsp_fault !== exp_fault || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL rsp_hold: valid=%b ppn=%h id=%h fault=%b req_ready=%b, want 1 %h %h %b 0",
                 rsp_valid, rsp_ppn, rsp_id, rsp_fault, req_ready, exp_ppn, id, exp_fault);
      end
    end
    rsp_ready = 1'b1;
    @(posedge ACLK);
    #1 rsp_ready = 1'b0;
    @(negedge ACLK);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rsp_release: rsp_valid=%b req_ready=%b, want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic flush_idle();
    flush = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_blocks_ready: req_ready=%b, want 0", req_ready);
    end
    @(posedge ACLK);
    #1 flush = 1'b0;
    cache.delete();
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    n_cmp++;
    if ({req_ready, rsp_valid, walk_valid, rsp_fault} !== 4'b0 || rsp_ppn !== 20'h0 ||
        rsp_id !== 4'h0 || walk_vpn !== 20'h0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b rv=%b wv=%b f=%b ppn=%h id=%h wvpn=%h, want all 0",
               req_ready, rsp_valid, walk_valid, rsp_fault, rsp_ppn, rsp_id, walk_vpn);
    end
`ifdef DEVICE_TLB_STATS_EN
    n_cmp++;
    if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      n_err++;
      $display("FAIL reset_stats: hit=%0d miss=%0d, want 0 0", hit_cnt, miss_cnt);
    end
`endif
    ARESET = 1'b0;
    cache.delete();
    exp_hits = 0;
    exp_misses = 0;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic test_cold_miss_and_hit();
    transact(20'h00012, 4'h3, 20'h0ABCD, 1'b0, 0, 1);
    transact(20'h00012, 4'h5, 20'h11111, 1'b0, 0, 0);
  endtask

  task automatic test_eviction();
    flush_idle();
    for (int v = 1; v <= 9; v++) transact(20'(v), 4'(v), 20'(32'h100 + v), 1'b0, 0, 0);
    transact(20'h00001, 4'hA, 20'h0F001, 1'b0, 0, 0);
    transact(20'h00009, 4'hB, 20'h0DEAD, 1'b0, 0, 0);
  endtask

  task automatic test_fault();
    transact(20'h00077, 4'h7, 20'h12345, 1'b1, 0, 0);
    transact(20'h00077, 4'h8, 20'h54321, 1'b0, 0, 0);
    transact(20'h00077, 4'h9, 20'h00000, 1'b0, 0, 0);
  endtask

  task automatic test_flush_during_walk();
    transact(20'h00033, 4'h1, 20'h03333, 1'b0, 1, 0);
    transact(20'h00033, 4'h2, 20'h04444, 1'b0, 0, 0);
    transact(20'h00044, 4'h3, 20'h05555, 1'b0, 2, 0);
    transact(20'h00044, 4'h4, 20'h06666, 1'b0, 0, 0);
  endtask

  task automatic test_rsp_backpressure();
    transact(20'h00044, 4'hC, 20'h0, 1'b0, 0, 5);
    transact(20'h00055, 4'hD, 20'h0BEEF, 1'b0, 0, 5);
  endtask

  task automatic test_reset_mid_walk();
    flush_idle();
    req_vpn = 20'h55555;
    req_id = 4'h6;
    req_valid = 1'b1;
    @(posedge ACLK);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge ACLK);
    walk_ready = 1'b1;
    @(posedge ACLK);
    #1 walk_ready = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    cache.delete();
    exp_hits = 0;
    exp_misses = 0;
    walk_done = 1'b1;
    walk_ppn = 20'h0AAAA;
    @(negedge ACLK);
    walk_done = 1'b0;
    repeat (2) @(negedge ACLK);
    n_cmp++;
    if (rsp_valid !== 1'b0 || walk_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL late_walk_done: rsp_valid=%b walk_valid=%b req_ready=%b, want 0 0 1",
               rsp_valid, walk_valid, req_ready);
    end
    transact(20'h55555, 4'h6, 20'h0CCCC, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    int fm;
    for (int t = 0; t < 160; t++) begin
      if ($urandom_range(0, 19) == 0) flush_idle();
      fm = $urandom_range(0, 9);
      transact(20'($urandom_range(0, 15)), 4'($urandom), 20'($urandom), ($urandom_range(0, 7) == 0),
               (fm < 2) ? fm + 1 : 0, $urandom_range(0, 2));
    end
  endtask

  task automatic test_stats();
`ifdef DEVICE_TLB_STATS_EN
    n_cmp++;
    if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
      n_err++;
      $display("FAIL stats_counts: hit=%0d miss=%0d, want %0d %0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
    stats_clr = 1'b1;
    @(posedge ACLK);
    #1 stats_clr = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    @(negedge ACLK);
    n_cmp++;
    if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      n_err++;
      $display("FAIL stats_clear: hit=%0d miss=%0d, want 0 0", hit_cnt, miss_cnt);
    end
    transact(20'h00099, 4'h1, 20'h09999, 1'b0, 0, 0);
    transact(20'h00099, 4'h2, 20'h0, 1'b0, 0, 0);
    n_cmp++;
    if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
      n_err++;
      $display("FAIL stats_after_clear: hit=%0d miss=%0d, want %0d %0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
`endif
  endtask

  initial begin
    ARESET = 1'b1;
    req_valid = 1'b0;
    req_vpn = '0;
    req_id = '0;
    rsp_ready = 1'b0;
    walk_ready = 1'b0;
    walk_done = 1'b0;
    walk_ppn = '0;
    walk_fault = 1'b0;
    flush = 1'b0;
`ifdef DEVICE_TLB_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_cold_miss_and_hit();
    test_rsp_backpressure();
    test_eviction();
    test_fault();
    test_flush_during_walk();
    test_stats();
    test_reset_mid_walk();
    test_random();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
